// File: rtl/nibble_serial_adder_if.sv
// nibble_serial_adder_if
//  Operand/result bundle for nibble_serial_adder.
//  master : operand source / result consumer (drives start, a, b, c_in)
//  slave  : the adder (drives ready, done, sum, c_out and, when
//           NSA_OVF_EN is defined, ovf)
//  Signals:
//   start  request, accepted on a clock edge where ready=1
//   a, b   WIDTH-bit operands, sampled on the accept edge
//   c_in   initial carry, sampled on the accept edge
//   ready  adder idle and able to accept
//   done   one-cycle pulse, sum/c_out hold a new result
//   sum    result register
//   c_out  carry out of the MSB nibble
//   ovf    signed overflow (NSA_OVF_EN only)
interface nibble_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             c_out;
`ifdef NSA_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, c_in,
    input  ready, done, sum, c_out
`ifdef NSA_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  start, a, b, c_in,
    output ready, done, sum, c_out
`ifdef NSA_OVF_EN
    , output ovf
`endif
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// nibble_serial_adder
//  Adds two WIDTH-bit operands one nibble per clock, LSB nibble first,
//  through a single 4-bit add stage with a registered carry between nibbles.
//  Handshake: start accepted when ready=1; done pulses for one cycle when
//  sum/c_out have been loaded with the new result.
//  Optional macro NSA_OVF_EN adds a signed-overflow output (bus.ovf).
//  Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    nibble_serial_adder_if.slave (start/a/b/c_in in,
//          ready/done/sum/c_out[/ovf] out)
module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  nibble_serial_adder_if.slave  bus
);

  localparam int NIB   = WIDTH / 4;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, b_sh_reg, acc_reg, sum_reg;
  logic             carry_reg, c_out_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [4:0]       nib_sum;
  logic [WIDTH-1:0] acc_next;
  logic             last_nib;
`ifdef NSA_OVF_EN
  logic             a_msb_reg, b_msb_reg, ovf_reg;
`endif

  // 4-bit add stage, 5 bits wide so bit 4 is the nibble carry out.
  assign nib_sum  = {1'b0, a_sh_reg[3:0]} + {1'b0, b_sh_reg[3:0]} + {4'b0, carry_reg};
  assign last_nib = (cnt_reg == CNT_W'(NIB - 1));

  // New nibble enters at the top; after NIB steps the LSB nibble is at the bottom.
  generate
    if (WIDTH == 4) begin : g_acc_single
      assign acc_next = nib_sum[3:0];
    end else begin : g_acc_shift
      assign acc_next = {nib_sum[3:0], acc_reg[WIDTH-1:4]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_nib)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      acc_reg   <= '0;
      carry_reg <= 1'b0;
      cnt_reg   <= '0;
      sum_reg   <= '0;
      c_out_reg <= 1'b0;
`ifdef NSA_OVF_EN
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      ovf_reg   <= 1'b0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            a_sh_reg  <= bus.a;
            b_sh_reg  <= bus.b;
            carry_reg <= bus.c_in;
            cnt_reg   <= '0;
`ifdef NSA_OVF_EN
            a_msb_reg <= bus.a[WIDTH-1];
            b_msb_reg <= bus.b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          acc_reg   <= acc_next;
          a_sh_reg  <= a_sh_reg >> 4;
          b_sh_reg  <= b_sh_reg >> 4;
          carry_reg <= nib_sum[4];
          cnt_reg   <= cnt_reg + 1'b1;
          // Result registers move only here, so partial sums never show.
          if (last_nib) begin
            sum_reg   <= acc_next;
            c_out_reg <= nib_sum[4];
`ifdef NSA_OVF_EN
            ovf_reg   <= (a_msb_reg == b_msb_reg) && (acc_next[WIDTH-1] != a_msb_reg);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ready = (state_reg == IDLE);
  assign bus.done  = (state_reg == DONE);
  assign bus.sum   = sum_reg;
  assign bus.c_out = c_out_reg;
`ifdef NSA_OVF_EN
  assign bus.ovf   = ovf_reg;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb_nibble_serial_adder
//  Directed bench for nibble_serial_adder at WIDTH=16.
//  Build with +define+NSA_OVF_EN to also check the overflow output.
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  nibble_serial_adder_if #(.WIDTH(WIDTH)) bus ();

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One add: accept on the next edge, count edges to done, check result.
  task automatic do_add(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic c_in, input logic [15:0] exp_sum,
                        input logic exp_cout, input logic exp_ovf);
    logic [15:0] prev_sum;
    int          cycles;
    @(negedge clk);
    check({tag, "_ready_before"}, 32'(bus.ready), 32'd1);
    prev_sum  = bus.sum;
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    bus.c_in  = c_in;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.a     = ~a;
    bus.b     = ~b;
    check({tag, "_ready_busy"}, 32'(bus.ready), 32'd0);
    cycles = 0;
    while (cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
      if (bus.done) break;
      check({tag, "_sum_hidden"}, 32'(bus.sum), 32'(prev_sum));
    end
    check({tag, "_latency"}, 32'(cycles), 32'(NIB));
    check({tag, "_done"}, 32'(bus.done), 32'd1);
    check({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
    check({tag, "_c_out"}, 32'(bus.c_out), 32'(exp_cout));
`ifdef NSA_OVF_EN
    check({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
`else
    if (exp_ovf === 1'bx) $display("unexpected ovf argument");
`endif
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
    check({tag, "_ready_after"}, 32'(bus.ready), 32'd1);
    check({tag, "_sum_hold"}, 32'(bus.sum), 32'(exp_sum));
    $display("add %s: a=0x%04h b=0x%04h c_in=%0d -> sum=0x%04h c_out=%0d latency=%0d",
             tag, a, b, c_in, bus.sum, bus.c_out, cycles);
  endtask

  initial begin
    int cycles;
    n_checks  = 0;
    n_fails   = 0;
    rst_n     = 1'b0;
    bus.start = 1'b1;
    bus.a     = 16'(($urandom));
    bus.b     = 16'(($urandom));
    bus.c_in  = 1'($urandom);

    // 1. reset with random inputs
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_done",  32'(bus.done),  32'd0);
    check("rst_sum",   32'(bus.sum),   32'd0);
    check("rst_c_out", 32'(bus.c_out), 32'd0);
`ifdef NSA_OVF_EN
    check("rst_ovf",   32'(bus.ovf),   32'd0);
`endif
    $display("reset: ready=%0d done=%0d sum=0x%04h c_out=%0d", bus.ready, bus.done, bus.sum, bus.c_out);
    @(negedge clk);
    bus.start = 1'b0;
    rst_n     = 1'b1;

    // 2./3. basic adds and full carry ripple
    do_add("basic",   16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
    do_add("ripple",  16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    do_add("all_ones",16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    do_add("mixed",   16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);

    // 4. start held high with changing operands: first result only,
    //    second op accepted on the first edge with ready=1
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'h0003;
    bus.b     = 16'h0004;
    bus.c_in  = 1'b0;
    @(posedge clk);
    #1;
    bus.a     = 16'h0100;
    bus.b     = 16'h0200;
    cycles    = 0;
    while (cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
      if (bus.done) break;
    end
    check("hold_lat1", 32'(cycles), 32'(NIB));
    check("hold_sum1", 32'(bus.sum), 32'h0007);
    $display("hold first: sum=0x%04h latency=%0d", bus.sum, cycles);
    cycles = 0;
    while (cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
      if (bus.done) break;
      check("hold_sum_stable", 32'(bus.sum), 32'h0007);
    end
    bus.start = 1'b0;
    check("hold_lat2", 32'(cycles), 32'(NIB + 2));
    check("hold_sum2", 32'(bus.sum), 32'h0300);
    $display("hold second: sum=0x%04h cycles_after_first_done=%0d", bus.sum, cycles);

    // 5. reset mid-RUN after two nibbles
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'h5555;
    bus.b     = 16'h2222;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_sum",   32'(bus.sum),   32'd0);
    check("abort_c_out", 32'(bus.c_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cycles = 0;
    repeat (NIB + 2) begin
      @(posedge clk);
      #1;
      if (bus.done) cycles++;
    end
    check("abort_no_done", 32'(cycles), 32'd0);
    check("abort_sum_hold", 32'(bus.sum), 32'd0);
    $display("abort: done pulses=%0d sum=0x%04h ready=%0d", cycles, bus.sum, bus.ready);
    do_add("after_abort", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);

    // 6. signed overflow cases (sum/c_out checked in every build)
    do_add("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_add("ovf_neg", 16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    do_add("no_ovf",  16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
